// File: rtl/barrett_pkg.sv
// Shared constants, the ID-width helper and the response record for the Barrett reduction arbiter.
package barrett_pkg;

    localparam int M0LEN_DEF   = 14;
    localparam int SHIFT_DEF   = 27;
    localparam int LATENCY_DEF = 4;
    localparam int NREQ_DEF    = 4;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEF = idw(NREQ_DEF);

    typedef struct packed {
        logic [IDW_DEF-1:0]   id;
        logic [M0LEN_DEF-1:0] quotient;
        logic [M0LEN_DEF-1:0] remainder;
    } rsp_t;

endpackage

// File: rtl/barrett_rsp_fifo.sv
// Synchronous response FIFO with registered pointers and an occupancy count; head is read combinationally.
module barrett_rsp_fifo #(
    parameter int  WIDTH = 30,
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_go, rd_go;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_go = rd_en_i & ~empty_o;
    assign wr_go = wr_en_i & (~full_o | rd_go);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_go) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (rd_go) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({wr_go, rd_go})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_go) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;

endmodule

// File: rtl/barrett_arbiter.sv
// Round-robin scheduler sharing one fixed-latency Barrett reduction pipe among NREQ requesters.
// Define BARRETT_ARB_FIXED_PRIO_EN to use fixed lowest-index-wins priority instead.
module barrett_arbiter
    import barrett_pkg::*;
#(
    parameter int  NREQ       = 4,
    parameter int  M0LEN      = M0LEN_DEF,
    parameter int  SHIFT      = SHIFT_DEF,
    parameter int  LATENCY    = LATENCY_DEF,
    parameter int  FIFO_DEPTH = 8,
    localparam int IDW        = idw(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*2*M0LEN-1:0] req_dividend,
    input  logic [NREQ*M0LEN-1:0]   req_m0,
    input  logic [NREQ*SHIFT-1:0]   req_m0_inverse,
    output logic [2*M0LEN-1:0]      bar_dividend,
    output logic [M0LEN-1:0]        bar_m0,
    output logic [SHIFT-1:0]        bar_m0_inverse,
    input  logic [M0LEN-1:0]        bar_quotient,
    input  logic [M0LEN-1:0]        bar_remainder,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [M0LEN-1:0]        rsp_quotient,
    output logic [M0LEN-1:0]        rsp_remainder,
    output logic                    busy
);
    localparam int DW  = 2 * M0LEN;
    localparam int RW  = IDW + 2 * M0LEN;
    localparam int CRW = $clog2(FIFO_DEPTH + 1);

    logic               grant_vld;
    logic [IDW-1:0]     grant_id;
    logic               credit_ok, issue, pop;
    logic [CRW-1:0]     reserved_q, reserved_d;
    logic [LATENCY-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [LATENCY];
    logic               fifo_empty, fifo_full;
    logic [CRW-1:0]     fifo_count;
    logic [RW-1:0]      fifo_rd_data;

`ifdef BARRETT_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Scan starts one past the last winner so every requester is reached within NREQ grants.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld && req_valid[rr_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_id  = rr_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        rr_ptr_d = issue ? grant_id : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= IDW'(NREQ - 1);
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign credit_ok = (reserved_q < CRW'(FIFO_DEPTH));
    assign issue     = grant_vld & credit_ok & ~rst;
    assign pop       = rsp_valid & rsp_ready;
    assign busy      = (reserved_q != '0);

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = issue & (grant_id == IDW'(gi));
    end

    assign bar_dividend   = req_dividend[int'(grant_id) * DW +: DW];
    assign bar_m0         = req_m0[int'(grant_id) * M0LEN +: M0LEN];
    assign bar_m0_inverse = req_m0_inverse[int'(grant_id) * SHIFT +: SHIFT];

    // Reserving a FIFO slot at issue guarantees every in-flight result has a home on return.
    always_comb begin
        reserved_d = reserved_q;
        if (issue && !pop)      reserved_d = reserved_q + 1'b1;
        else if (!issue && pop) reserved_d = reserved_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved_q <= '0;
            tag_vld_q  <= '0;
        end else begin
            reserved_q   <= reserved_d;
            tag_vld_q[0] <= issue;
            for (int s = LATENCY - 1; s > 0; s--) tag_vld_q[s] <= tag_vld_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_id;
        for (int s = LATENCY - 1; s > 0; s--) tag_id_q[s] <= tag_id_q[s-1];
    end

    barrett_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (tag_vld_q[LATENCY-1]),
        .wr_data_i ({tag_id_q[LATENCY-1], bar_quotient, bar_remainder}),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    assign rsp_valid = ~fifo_empty;
    assign {rsp_id, rsp_quotient, rsp_remainder} = fifo_rd_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(tag_vld_q[LATENCY-1] && fifo_full && !pop))
                else $error("barrett_arbiter: response FIFO written while full");
            assert (fifo_count <= reserved_q)
                else $error("barrett_arbiter: FIFO occupancy exceeds reserved count");
        end
    end

endmodule

// File: tb/tb_barrett_arbiter.sv
// Directed self-checking bench for barrett_arbiter with a behavioural 4-stage Barrett unit model.
module tb_barrett_arbiter;
    import barrett_pkg::*;

    localparam int NREQ = 4, M0LEN = 14, SHIFT = 27, LATENCY = 4, FIFO_DEPTH = 8;
    localparam int IDW = 2, DW = 2 * M0LEN;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid, req_ready;
    logic [NREQ*DW-1:0]      req_dividend;
    logic [NREQ*M0LEN-1:0]   req_m0;
    logic [NREQ*SHIFT-1:0]   req_m0_inverse;
    logic [DW-1:0]           bar_dividend;
    logic [M0LEN-1:0]        bar_m0, bar_quotient, bar_remainder;
    logic [SHIFT-1:0]        bar_m0_inverse;
    logic                    rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]          rsp_id;
    logic [M0LEN-1:0]        rsp_quotient, rsp_remainder;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    barrett_arbiter #(
        .NREQ(NREQ), .M0LEN(M0LEN), .SHIFT(SHIFT), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_m0(req_m0), .req_m0_inverse(req_m0_inverse),
        .bar_dividend(bar_dividend), .bar_m0(bar_m0), .bar_m0_inverse(bar_m0_inverse),
        .bar_quotient(bar_quotient), .bar_remainder(bar_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .busy(busy)
    );

    // Barrett unit model: operands sampled at the issue edge, result visible before the 4th following edge.
    logic [DW-1:0]    p_div [LATENCY];
    logic [M0LEN-1:0] p_m0  [LATENCY];
    always @(posedge clk) begin
        p_div[0] <= bar_dividend;
        p_m0[0]  <= bar_m0;
        for (int s = 1; s < LATENCY; s++) begin
            p_div[s] <= p_div[s-1];
            p_m0[s]  <= p_m0[s-1];
        end
    end
    always_comb begin
        bar_quotient  = '0;
        bar_remainder = '0;
        if (p_m0[LATENCY-1] != '0) begin
            bar_quotient  = M0LEN'(p_div[LATENCY-1] / DW'(p_m0[LATENCY-1]));
            bar_remainder = M0LEN'(p_div[LATENCY-1] % DW'(p_m0[LATENCY-1]));
        end
    end

    function automatic rsp_t model(input int i);
        rsp_t m;
        int   dv, md;
        dv = int'(req_dividend[i*DW +: DW]);
        md = int'(req_m0[i*M0LEN +: M0LEN]);
        m.id        = IDW'(i);
        m.quotient  = M0LEN'(dv / md);
        m.remainder = M0LEN'(dv % md);
        return m;
    endfunction

    task automatic set_op(input int i, input int dv, input int md);
        req_dividend[i*DW +: DW]         = DW'(dv);
        req_m0[i*M0LEN +: M0LEN]         = M0LEN'(md);
        req_m0_inverse[i*SHIFT +: SHIFT] = SHIFT'((1 << 27) / md);
    endtask

    task automatic record_issues();
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back(model(i));
                $display("issue req=%0d dividend=%0d m0=%0d", i,
                         req_dividend[i*DW +: DW], req_m0[i*M0LEN +: M0LEN]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    endtask

    task automatic test_single_op();
        int lat;
        lat = 0;
        @(negedge clk);
        set_op(2, 1000000, 4591);
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        total++; if (bar_dividend !== 28'd1000000 || bar_m0 !== 14'd4591 || bar_m0_inverse !== 27'd29234) begin
            bad++; $display("FAIL single_bar_mux: got %0d/%0d/%0d want 1000000/4591/29234", bar_dividend, bar_m0, bar_m0_inverse);
        end
        @(negedge clk);
        req_valid = '0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (n == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
            end
            if (rsp_valid === 1'b1) begin lat = n; break; end
            @(negedge clk);
        end
        total++; if (lat != 5) begin bad++; $display("FAIL single_latency: got %0d edges want 5", lat); end
        $display("rsp id=%0d q=%0d r=%0d", rsp_id, rsp_quotient, rsp_remainder);
        total++; if (rsp_id !== 2'd2 || rsp_quotient !== 14'd217 || rsp_remainder !== 14'd3753) begin
            bad++; $display("FAIL single_data: got id=%0d q=%0d r=%0d want id=2 q=217 r=3753", rsp_id, rsp_quotient, rsp_remainder);
        end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_drain: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want_g;
        rsp_t       got, want;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 100000 + 3001 * i, 1009 + 50 * i);
        rsp_ready = 1'b1; req_valid = '1;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) req_valid = '0;
            #1;
            if (c < 12) begin
                want_g = 4'b0001 << (c % 4);
                total++; if (req_ready !== want_g) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, want_g); end
            end
            record_issues();
            if (rsp_valid && rsp_ready) begin
                got = {rsp_id, rsp_quotient, rsp_remainder};
                $display("rsp id=%0d q=%0d r=%0d", rsp_id, rsp_quotient, rsp_remainder);
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                total++; if (got !== want) begin bad++; $display("FAIL rr_rsp: got %h want %h", got, want); end
            end
            @(negedge clk);
        end
        #1;
        total++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rr_drain: got pending=%0d busy=%b want 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        set_op(1, 80000, 2011); set_op(3, 90000, 3011);
        rsp_ready = 1'b1; req_valid = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL fp_grant[%0d]: got %b want 0010", c, req_ready); end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (12) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fp_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int   hs, nop, res, sim7;
        logic hs_n, pop_n, want_r;
        rsp_t got, want;
        hs = 0; nop = 0; sim7 = 0;
        do_reset();
        set_op(0, 50000, 3001);
        req_valid = 4'b0001; rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            hs_n = req_valid[0] & req_ready[0];
            record_issues();
            if (hs_n) hs++;
            @(negedge clk);
            if (hs_n) begin nop++; set_op(0, 50000 + 1234 * nop, 3001 + 2 * nop); end
        end
        #1;
        total++; if (hs != 8) begin bad++; $display("FAIL bp_handshakes: got %0d want 8", hs); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_blocked: got %b want 0000", req_ready); end
        got  = {rsp_id, rsp_quotient, rsp_remainder};
        want = (exp_q.size() != 0) ? exp_q[0] : '1;
        total++; if (rsp_valid !== 1'b1 || got !== want) begin
            bad++; $display("FAIL bp_head_hold: got valid=%b %h want 1 %h", rsp_valid, got, want);
        end
        rsp_ready = 1'b1;
        res = 8;
        for (int c = 0; c < 50; c++) begin
            if (c == 30) req_valid = '0;
            #1;
            want_r = req_valid[0] && (res < FIFO_DEPTH);
            total++; if (req_ready[0] !== want_r) begin bad++; $display("FAIL bp_credit[%0d]: got %b want %b (reserved=%0d)", c, req_ready[0], want_r, res); end
            hs_n  = req_valid[0] & req_ready[0];
            pop_n = rsp_valid & rsp_ready;
            record_issues();
            if (pop_n) begin
                got = {rsp_id, rsp_quotient, rsp_remainder};
                $display("rsp id=%0d q=%0d r=%0d", rsp_id, rsp_quotient, rsp_remainder);
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                total++; if (got !== want) begin bad++; $display("FAIL bp_rsp: got %h want %h", got, want); end
            end
            if (hs_n && pop_n && res == 7) sim7++;
            res = res + int'(hs_n) - int'(pop_n);
            @(negedge clk);
            if (hs_n) begin nop++; set_op(0, 50000 + 1234 * nop, 3001 + 2 * nop); end
        end
        #1;
        total++; if (sim7 == 0) begin bad++; $display("FAIL bp_issue_pop_at7: got %0d events want >0", sim7); end
        total++; if (exp_q.size() != 0 || busy !== 1'b0 || res != 0) begin
            bad++; $display("FAIL bp_drain: got pending=%0d busy=%b reserved=%0d want 0/0/0", exp_q.size(), busy, res);
        end
    endtask

    task automatic test_reset_midflight();
        int hs, seen, lat;
        hs = 0; seen = 0; lat = 0;
        do_reset();
        set_op(0, 200000, 2003);
        rsp_ready = 1'b1; req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (req_ready[0]) hs++;
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        total++; if (hs != 3) begin bad++; $display("FAIL mid_issued: got %0d want 3", hs); end
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 0) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
            end
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_stale_rsp: got %0d cycles want 0", seen); end
        set_op(1, 777777, 9973);
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_ready: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (rsp_valid === 1'b1) begin lat = n; break; end
            @(negedge clk);
        end
        $display("rsp id=%0d q=%0d r=%0d", rsp_id, rsp_quotient, rsp_remainder);
        total++; if (lat != 5 || rsp_id !== 2'd1 || rsp_quotient !== 14'd77 || rsp_remainder !== 14'd9856) begin
            bad++; $display("FAIL mid_next_op: got lat=%0d id=%0d q=%0d r=%0d want 5/1/77/9856", lat, rsp_id, rsp_quotient, rsp_remainder);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_dividend = '0; req_m0 = '0; req_m0_inverse = '0;
        test_reset();
        test_single_op();
`ifdef BARRETT_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
